// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with writeback scoreboard and self-clearing init; optional REG_FILE_BYPASS_EN
module reg_file_sb #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          rd_en,
    input  logic [AW-1:0] rd,
    input  logic [N-1:0]  write_data,
    input  logic          reg_write,
    input  logic          busy_set,
    input  logic [AW-1:0] busy_addr,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2,
    output logic          busy1,
    output logic          busy2,
    output logic          ready
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [N-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [N-1:0]    rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic            wr_en;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [N-1:0]    mem_wdata;
    logic [N-1:0]    rval1, rval2;

    assign ready  = (state_q == READY);
    assign wr_en  = ready && reg_write && (rd != '0);
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign busy1  = ready && (rs1 != '0) && busy_q[rs1];
    assign busy2  = ready && (rs2 != '0) && busy_q[rs2];

    // Control state: clear walker position and FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: walk every entry once, then park in READY without wrapping the counter
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST) state_d = READY;
                else                   clr_cnt_d = clr_cnt_q + 1'b1;
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Single write port shared by the clear walker and normal writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rd;
        mem_wdata = write_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Storage array has no reset; the clear walk is its only initialisation
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // Read values: entry 0 is hardwired zero, optional write-to-read forwarding
    always_comb begin
        rval1 = (rs1 == '0) ? '0 : mem_q[rs1];
        rval2 = (rs2 == '0) ? '0 : mem_q[rs2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (rs1 == rd)) rval1 = write_data;
        if (wr_en && (rs2 == rd)) rval2 = write_data;
`endif
    end

    // Scoreboard and read-capture next state; a new issue wins over a same-cycle writeback
    always_comb begin
        busy_d   = busy_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (state_q == CLEAR) begin
            busy_d[clr_cnt_q] = 1'b0;
        end else begin
            if (wr_en) busy_d[rd] = 1'b0;
            if (busy_set && (busy_addr != '0)) busy_d[busy_addr] = 1'b1;
            if (rd_en) begin
                rdata1_d = rval1;
                rdata2_d = rval2;
            end
        end
    end

    // Scoreboard bits and captured read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            busy_q   <= busy_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd, busy_addr;
    logic        rd_en, reg_write, busy_set;
    logic [31:0] write_data;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2, ready;

    int checks = 0;
    int errors = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        ren;
        logic [4:0]  rs1, rs2;
        logic        bset;
        logic [4:0]  baddr;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
    } vec_t;

    typedef struct {
        logic [31:0] r1, r2;
    } exp_t;

    vec_t vecs[16];
    exp_t sb_q[$];

    reg_file_sb #(.N(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd_en(rd_en),
        .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int we, input int rdi, input logic [31:0] wd,
                                input int ren, input int a1, input int a2,
                                input int bs, input int ba,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input int eb1, input int eb2);
        vec_t v;
        v.we = 1'(we); v.rd = 5'(rdi); v.wd = wd; v.ren = 1'(ren);
        v.rs1 = 5'(a1); v.rs2 = 5'(a2); v.bset = 1'(bs); v.baddr = 5'(ba);
        v.e1 = e1; v.e2 = e2; v.eb1 = 1'(eb1); v.eb2 = 1'(eb2);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    task automatic idle();
        reg_write = 1'b0; rd_en = 1'b0; busy_set = 1'b0;
        rd = '0; write_data = '0; busy_addr = '0; rs1 = '0; rs2 = '0;
    endtask

    // Drive one vector, queue its expected read data, compare after the edge
    task automatic step(input string name, input vec_t v);
        exp_t e;
        reg_write = v.we; rd = v.rd; write_data = v.wd; rd_en = v.ren;
        rs1 = v.rs1; rs2 = v.rs2; busy_set = v.bset; busy_addr = v.baddr;
        e.r1 = v.e1; e.r2 = v.e2;
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rdata1"}, rdata1, e.r1);
            chk({name, "_rdata2"}, rdata2, e.r2);
        end
        chk1({name, "_busy1"}, busy1, v.eb1);
        chk1({name, "_busy2"}, busy2, v.eb2);
        chk1({name, "_ready"}, ready, 1'b1);
    endtask

    // Count edges after reset release until ready, bounded
    task automatic wait_ready(input string name);
        int cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (ready) break;
        end
        chk({name, "_cycles_to_ready"}, 32'(cnt), 32'd32);
    endtask

    initial begin
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h1234,     0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,        1, 0, 5, 0, 0, 32'h0, 32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(1, 7, 32'h3,        0, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0, 0);
        vecs[5]  = mk(1, 7, 32'hA,        1, 7, 5, 0, 0, BYP ? 32'hA : 32'h3, 32'hDEADBEEF, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,        1, 7, 7, 0, 0, 32'hA, 32'hA, 0, 0);
        vecs[7]  = mk(1, 3, 32'h55,       0, 0, 0, 0, 0, 32'hA, 32'hA, 0, 0);
        vecs[8]  = mk(1, 3, 32'h0,        1, 3, 3, 0, 0, BYP ? 32'h0 : 32'h55, BYP ? 32'h0 : 32'h55, 0, 0);
        vecs[9]  = mk(0, 0, 32'h0,        1, 3, 5, 0, 0, 32'h0, 32'hDEADBEEF, 0, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 9, 9, 1, 9, 32'h0, 32'hDEADBEEF, 1, 1);
        vecs[11] = mk(1, 9, 32'h99,       0, 0, 9, 1, 9, 32'h0, 32'hDEADBEEF, 0, 1);
        vecs[12] = mk(1, 9, 32'h77,       0, 9, 9, 0, 0, 32'h0, 32'hDEADBEEF, 0, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 9, 1, 0, 32'h0, 32'hDEADBEEF, 0, 0);
        vecs[14] = mk(0, 0, 32'h0,        1, 9, 0, 0, 0, 32'h77, 32'h0, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,        0, 31, 30, 1, 31, 32'h77, 32'h0, 1, 0);

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_ready", ready, 1'b0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_rdata2", rdata2, 32'h0);
        rst_n = 1'b1;
        wait_ready("init");

        for (int i = 0; i < 32; i++)
            step($sformatf("zero_rd%0d", i), mk(0, 0, 32'h0, 1, i, 31 - i, 0, 0, 32'h0, 32'h0, 0, 0));

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of the clear walk restarts it from entry 0
        idle();
        rs1 = 5'd31;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk1("midclear_ready", ready, 1'b0);
        chk1("midclear_busy1", busy1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rereset_rdata1", rdata1, 32'h0);
        rst_n = 1'b1;
        reg_write = 1'b1; rd = 5'd2; write_data = 32'h5A5A; busy_set = 1'b1; busy_addr = 5'd2;
        rd_en = 1'b1; rs1 = 5'd2; rs2 = 5'd5;
        wait_ready("rereset");
        idle();
        rs1 = 5'd2;
        #1;
        chk("ignored_rd_en_rdata1", rdata1, 32'h0);
        chk1("ignored_busy_set", busy1, 1'b0);
        step("post_r5_r2", mk(0, 0, 32'h0, 1, 5, 2, 0, 0, 32'h0, 32'h0, 0, 0));
        step("post_busy31", mk(0, 0, 32'h0, 0, 31, 9, 0, 0, 32'h0, 32'h0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter N, default 32, data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width; DEPTH = 2**AW entries.
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide ports rs1, rs2  input  AW  read addresses.
REQ-006 SHALL provide port rd_en  input  1  capture read data into rdata1/rdata2.
REQ-007 SHALL provide port rd  input  AW  write address.
REQ-008 SHALL provide port write_data  input  N  write data.
REQ-009 SHALL provide port reg_write  input  1  write strobe.
REQ-010 SHALL provide port busy_set  input  1  mark busy_addr as pending writeback.
REQ-011 SHALL provide port busy_addr  input  AW  scoreboard address to mark.
REQ-012 SHALL provide ports rdata1, rdata2  output  N  registered read data.
REQ-013 SHALL provide ports busy1, busy2  output  1  pending flag of rs1/rs2, combinational.
REQ-014 SHALL provide port ready  output  1  clear sequence complete, block accepts operations.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, SHALL write zero to entry clr_cnt and clear busy[clr_cnt] each cycle, clr_cnt incrementing 0..DEPTH-1.
REQ-017 On the cycle clr_cnt = DEPTH-1 is cleared, SHALL transition to READY; ready = 1 from the next cycle; clr_cnt does not wrap back.
REQ-018 While ready = 0, SHALL ignore reg_write, rd_en and busy_set.
REQ-019 In READY, reg_write = 1 with rd != 0 SHALL store write_data into entry rd at the edge, including write_data = 0.
REQ-020 Entry 0 SHALL always read as zero; writes and busy_set to address 0 SHALL be ignored.
REQ-021 rd_en = 1 SHALL load rdata1/rdata2 from entries rs1/rs2 at the edge (latency 1); rd_en = 0 SHALL hold rdata1/rdata2.
REQ-022 reg_write to rd != 0 SHALL clear busy[rd]; busy_set SHALL set busy[busy_addr].
REQ-023 Simultaneous busy_set and reg_write to the same address SHALL leave busy set (new issue wins).
REQ-024 busy1/busy2 SHALL equal busy[rs1]/busy[rs2] combinationally; both 0 for address 0 and while ready = 0.
REQ-025 Same-cycle read and write to the same nonzero address: behaviour per REQ-030/REQ-031.

Reset
REQ-026 rst_n = 0 at a rising edge SHALL force state CLEAR, clr_cnt = 0, ready = 0, rdata1 = rdata2 = 0.
REQ-027 Reset asserted mid-clear or in READY SHALL restart the full clear sequence from entry 0; no partial state survives.
REQ-028 After rst_n deasserts, ready SHALL rise exactly DEPTH cycles later.
REQ-029 Entry contents SHALL NOT rely on initial blocks; the clear sequence is the only initialisation.

Configuration
REQ-030 With macro REG_FILE_BYPASS_EN defined, rd_en with rs1 or rs2 equal to a same-cycle written rd != 0 SHALL capture write_data into that rdata.
REQ-031 Without REG_FILE_BYPASS_EN, the same case SHALL capture the pre-write entry value; the written value is visible from the next read.

Verification
REQ-032 Reset, count cycles to ready -> ready = 1 exactly 32 cycles after rst_n rises (defaults); rdata1/2 = 0 and all reads return 0.
REQ-033 Write 0xDEADBEEF to r5, next cycle rd_en with rs1 = 5, rs2 = 0 -> rdata1 = 0xDEADBEEF, rdata2 = 0; write 0x1234 to r0 then read -> 0.
REQ-034 Write 0xA to r7 while rd_en, rs1 = 7 (r7 previously 0x3) -> rdata1 = 0xA with REG_FILE_BYPASS_EN, 0x3 without.
REQ-035 busy_set r9, rs2 = 9 -> busy2 = 1; next cycle busy_set r9 and reg_write r9 together -> busy2 stays 1; following reg_write r9 alone -> busy2 = 0.
REQ-036 Assert rst_n = 0 at clr_cnt = 10, release -> ready = 0 for a further 32 cycles; previously written r5 reads 0 afterwards.
